cam_pixel_packer: RTL and testbench
===================================

# cam_pixel_packer

Upstream feeder of the 285-bit frame-write FIFO in the HDR capture path. Accepts one 16-bit RGB565 pixel per cycle from the camera capture stage, packs 16 pixels into a 256-bit word, and prepends a 29-bit DDR word address. The address is derived from the exposure buffer index and the running word index. Pushes each completed {addr, data} entry into the FIFO write port; the camera cannot be stalled, so words that meet a full FIFO are dropped and flagged.

## Interface
- PIX_W, 16, pixel width in bits
- PIX_PER_WORD, 16, pixels per 256-bit word (PIX_W*PIX_PER_WORD = 256)
- ADDR_W, 29, DDR word address width
- FRAME_WORDS, 19200, words per frame (640x480/16)
- BUF_LOG2, 15, log2 of per-exposure buffer stride in words (2^BUF_LOG2 >= FRAME_WORDS)
- clk  in  1  system clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of frame (from vsync)
- exposure_sel  in  2  exposure buffer index 0..2, sampled on frame_start
- pix_valid  in  1  pixel strobe
- pix_data  in  16  pixel value
- fifo_full  in  1  FIFO Full
- fifo_almost_full  in  1  FIFO AlmostFull, status only
- fifo_data  out  285  {addr[28:0], data[255:0]}
- fifo_wr_en  out  1  FIFO WrEn, one cycle per word
- frame_done  out  1  one-cycle pulse after the last word of a frame is issued
- overflow  out  1  sticky: a word was dropped
- clr_overflow  in  1  clears overflow and drop_count
- drop_count  out  16  saturating count of dropped words
- busy  out  1  high in ACTIVE

## Operation
- FSM states: IDLE, ACTIVE.
- IDLE: pix_valid is ignored. On frame_start: latch exposure_sel, clear word_idx and lane counter, go to ACTIVE.
- ACTIVE: each pix_valid writes pix_data into lane `lane` (lane 0 = bits [15:0], lane 15 = bits [255:240]), then lane++.
- On the 16th pixel (lane = 15):
  - Word completes. addr = {zero pad, buf[1:0], word_idx[BUF_LOG2-1:0]}, zero-extended to 29 bits.
  - If fifo_full = 0: register fifo_data and assert fifo_wr_en next cycle.
  - If fifo_full = 1: drop the word, set overflow, increment drop_count (saturates at 0xFFFF).
  - word_idx increments in both cases, so addresses stay frame-aligned.
- When the completed word has word_idx = FRAME_WORDS-1: pulse frame_done, return to IDLE.
- frame_start while ACTIVE: discard the partial word, set overflow, restart with the newly latched exposure_sel. No frame_done.
- exposure_sel = 3 is treated as 2.
- fifo_almost_full only drives busy-independent status; it is never used to throttle.
- clr_overflow has priority over a same-cycle set.

## Timing
- Reset values: fifo_data = 0, fifo_wr_en = 0, frame_done = 0, overflow = 0, drop_count = 0, busy = 0, FSM = IDLE.
- Latency: 16th pixel accepted at cycle N -> fifo_wr_en high and fifo_data valid at cycle N+1, high for exactly one cycle.
- fifo_full is sampled in cycle N (the completing cycle).
- frame_done is coincident with the final fifo_wr_en, or with the final drop.
- Back-to-back pixels sustain 1 word per 16 cycles. A pixel on the cycle after completion goes to lane 0 of the next word.
- rst_n is asserted asynchronously mid-frame: all state clears immediately and no partial word is emitted.

## Structure
- Shared package cam_pkg holds:
  - PIX_W, PIX_PER_WORD, ADDR_W, FIFO_W = 285
  - FRAME_WORDS, BUF_LOG2
  - fifo entry field offsets (DATA_LSB = 0, ADDR_LSB = 256)
- Optional sub-module: cam_addr_gen (buf latch + word_idx counter + address concat + last-word detect).
- Packing shift register and FSM live in the top.

## Test plan
- Reset, frame_start with exposure_sel=1, 32 pixels with values 0..31:
  - First word: fifo_wr_en one cycle after pixel 15, data[15:0]=0, data[255:240]=15, addr=0x8000.
  - Second word: addr=0x8001.
- Full frame: 307200 pixels, exposure_sel=2 -> 19200 writes, last addr=0x10000+19199, frame_done coincident with the last write, busy drops, subsequent pix_valid ignored.
- fifo_full held high across the 3rd word completion:
  - That word is not written; overflow=1, drop_count=1.
  - The 4th word is written with addr=base+3.
  - clr_overflow -> overflow=0, drop_count=0.
- frame_start after 100 pixels:
  - Partial word (pixels 96..99) is discarded; overflow=1.
  - The next word uses addr = new base + 0.
- rst_n pulsed low after 8 pixels of a word: no fifo_wr_en, all outputs 0. After release, pixels without frame_start produce no writes.
- Gapped pix_valid (1 every 3 cycles): packing order preserved and word emitted one cycle after the 16th valid.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared constants and types for the camera pixel packer.
package cam_pkg;

    localparam int unsigned PIX_W        = 16;
    localparam int unsigned PIX_PER_WORD = 16;
    localparam int unsigned ADDR_W       = 29;
    localparam int unsigned FIFO_W       = 285;
    localparam int unsigned FRAME_WORDS  = 19200;
    localparam int unsigned BUF_LOG2     = 15;

    // Field offsets inside one FIFO entry {addr, data}
    localparam int unsigned DATA_LSB     = 0;
    localparam int unsigned ADDR_LSB     = 256;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    // Only three exposure buffers exist; index 3 folds onto buffer 2.
    function automatic logic [1:0] buf_index(input logic [1:0] sel);
        return (sel == 2'd3) ? 2'd2 : sel;
    endfunction

endpackage

// File: rtl/cam_addr_gen.sv
// Exposure buffer latch, running word index and DDR word address generation.
module cam_addr_gen #(
    parameter int unsigned ADDR_W      = cam_pkg::ADDR_W,
    parameter int unsigned FRAME_WORDS = cam_pkg::FRAME_WORDS,
    parameter int unsigned BUF_LOG2    = cam_pkg::BUF_LOG2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        sel,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    import cam_pkg::*;

    logic [1:0]          buf_q;
    logic [BUF_LOG2-1:0] word_idx;

    // Latch the buffer on frame start; step the word index on every completed word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q    <= '0;
            word_idx <= '0;
        end else if (start) begin
            buf_q    <= buf_index(sel);
            word_idx <= '0;
        end else if (advance) begin
            word_idx <= word_idx + BUF_LOG2'(1);
        end
    end

    // Buffer index sits directly above the word index, zero-extended to the bus width
    always_comb begin
        addr = ADDR_W'({buf_q, word_idx});
        last = (word_idx == BUF_LOG2'(FRAME_WORDS - 1));
    end

endmodule

// File: rtl/cam_pixel_packer.sv
// Packs RGB565 pixels 16 at a time into addressed 256-bit FIFO entries.
module cam_pixel_packer #(
    parameter int unsigned PIX_W        = cam_pkg::PIX_W,
    parameter int unsigned PIX_PER_WORD = cam_pkg::PIX_PER_WORD,
    parameter int unsigned ADDR_W       = cam_pkg::ADDR_W,
    parameter int unsigned FRAME_WORDS  = cam_pkg::FRAME_WORDS,
    parameter int unsigned BUF_LOG2     = cam_pkg::BUF_LOG2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  frame_start,
    input  logic [1:0]                            exposure_sel,
    input  logic                                  pix_valid,
    input  logic [PIX_W-1:0]                      pix_data,
    input  logic                                  fifo_full,
    input  logic                                  fifo_almost_full,
    output logic [ADDR_W+PIX_W*PIX_PER_WORD-1:0]  fifo_data,
    output logic                                  fifo_wr_en,
    output logic                                  frame_done,
    output logic                                  overflow,
    input  logic                                  clr_overflow,
    output logic [15:0]                           drop_count,
    output logic                                  busy
);
    import cam_pkg::*;

    localparam int unsigned WORD_W = PIX_W * PIX_PER_WORD;
    localparam int unsigned LANE_W = $clog2(PIX_PER_WORD);

    state_t              state;
    logic [LANE_W-1:0]   lane;
    logic [WORD_W-1:0]   sr;
    logic [WORD_W-1:0]   word_next;
    logic [ADDR_W-1:0]   addr;
    logic                last_word;
    logic                word_done;
    logic                drop;
    logic                abort;

    // AlmostFull is status only and never throttles the camera
    logic                unused_status;
    assign unused_status = fifo_almost_full;

    cam_addr_gen #(
        .ADDR_W      (ADDR_W),
        .FRAME_WORDS (FRAME_WORDS),
        .BUF_LOG2    (BUF_LOG2)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (frame_start),
        .sel     (exposure_sel),
        .advance (word_done),
        .addr    (addr),
        .last    (last_word)
    );

    // Word completion, drop and abort conditions for the current cycle
    always_comb begin
        // New pixels enter at the top, so after 16 shifts the first pixel sits in lane 0
        word_next = {pix_data, sr[WORD_W-1:PIX_W]};
        word_done = (state == ACTIVE) && !frame_start && pix_valid
                    && (lane == LANE_W'(PIX_PER_WORD - 1));
        drop      = word_done && fifo_full;
        abort     = (state == ACTIVE) && frame_start;
    end

    // Frame FSM, packing shift register and registered FIFO write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            lane       <= '0;
            sr         <= '0;
            fifo_data  <= '0;
            fifo_wr_en <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            fifo_wr_en <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state <= ACTIVE;
                        busy  <= 1'b1;
                        lane  <= '0;
                    end
                end
                ACTIVE: begin
                    if (frame_start) begin
                        lane <= '0;
                    end else if (pix_valid) begin
                        sr   <= word_next;
                        lane <= lane + LANE_W'(1);
                        if (word_done) begin
                            if (!fifo_full) begin
                                fifo_data  <= {addr, word_next};
                                fifo_wr_en <= 1'b1;
                            end
                            if (last_word) begin
                                frame_done <= 1'b1;
                                state      <= IDLE;
                                busy       <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow and saturating drop counter; clear beats a same-cycle set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clr_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (drop || abort)
                overflow <= 1'b1;
            if (drop && (drop_count != '1))
                drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Scoreboard bench for cam_pixel_packer, using a short frame so a full frame fits the run.
module tb_cam_pixel_packer;

    localparam int unsigned FW = 40;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         frame_start;
    logic [1:0]   exposure_sel;
    logic         pix_valid;
    logic [15:0]  pix_data;
    logic         fifo_full;
    logic         fifo_almost_full;
    logic [284:0] fifo_data;
    logic         fifo_wr_en;
    logic         frame_done;
    logic         overflow;
    logic         clr_overflow;
    logic [15:0]  drop_count;
    logic         busy;

    typedef struct {
        logic [28:0]  addr;
        logic [255:0] data;
        logic         done;
        int unsigned  cyc;
    } exp_t;

    exp_t        q[$];
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc   = 0;

    cam_pixel_packer #(
        .FRAME_WORDS (FW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .frame_start      (frame_start),
        .exposure_sel     (exposure_sel),
        .pix_valid        (pix_valid),
        .pix_data         (pix_data),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .fifo_data        (fifo_data),
        .fifo_wr_en       (fifo_wr_en),
        .frame_done       (frame_done),
        .overflow         (overflow),
        .clr_overflow     (clr_overflow),
        .drop_count       (drop_count),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write is popped against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (fifo_wr_en) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write: got addr %0h expected no write", fifo_data[284:256]);
                end else begin
                    e = q.pop_front();
                    if (fifo_data[284:256] !== e.addr || fifo_data[255:0] !== e.data
                        || frame_done !== e.done || cyc != e.cyc) begin
                        fails++;
                        $display("FAIL write: got addr %0h done %0b cyc %0d data %h expected addr %0h done %0b cyc %0d data %h",
                                 fifo_data[284:256], frame_done, cyc, fifo_data[255:0],
                                 e.addr, e.done, e.cyc, e.data);
                    end
                end
            end else if (frame_done) begin
                tests++;
                fails++;
                $display("FAIL frame_done_alone: got 1 expected 0");
            end
        end
    end

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk); #1;
            pix_valid = 1'b0;
            fifo_full = 1'b0;
        end
    endtask

    task automatic pulse_start(input logic [1:0] sel);
        @(posedge clk); #1;
        frame_start  = 1'b1;
        exposure_sel = sel;
        pix_valid    = 1'b0;
        fifo_full    = 1'b0;
        @(posedge clk); #1;
        frame_start  = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        clr_overflow = 1'b1;
        pix_valid    = 1'b0;
        @(posedge clk); #1;
        clr_overflow = 1'b0;
    endtask

    // Sixteen pixels base..base+15, `gap` idle cycles after each; expectation pushed on the 16th
    task automatic send_word(input logic [15:0] base, input int unsigned gap, input logic full,
                             input logic exp_wr, input logic [28:0] exp_addr, input logic exp_done);
        exp_t e;
        e.data = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            pix_valid = 1'b1;
            pix_data  = base + 16'(i);
            fifo_full = full;
            e.data[i*16 +: 16] = base + 16'(i);
            if (i == 15 && exp_wr) begin
                e.addr = exp_addr;
                e.done = exp_done;
                e.cyc  = cyc + 1;
                q.push_back(e);
            end
            for (int unsigned g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                pix_valid = 1'b0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        frame_start      = 1'b0;
        exposure_sel     = 2'd0;
        pix_valid        = 1'b0;
        pix_data         = 16'h0;
        fifo_full        = 1'b0;
        fifo_almost_full = 1'b0;
        clr_overflow     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        check("rst_data",  64'(|fifo_data), 64'd0);
        check("rst_done",  64'(frame_done), 64'd0);
        check("rst_ovf",   64'(overflow), 64'd0);
        check("rst_drops", 64'(drop_count), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        rst_n = 1'b1;

        // Pixels before any frame_start are ignored
        send_word(16'h1000, 0, 1'b0, 1'b0, 29'h0, 1'b0);
        idle(2);
        check("idle_busy", 64'(busy), 64'd0);

        // Exposure 1: two words at 0x8000 and 0x8001
        pulse_start(2'd1);
        check("start_busy", 64'(busy), 64'd1);
        send_word(16'd0,  0, 1'b0, 1'b1, 29'h8000, 1'b0);
        send_word(16'd16, 0, 1'b0, 1'b1, 29'h8001, 1'b0);
        idle(3);
        check("ovf_clean", 64'(overflow), 64'd0);

        // Restart with exposure 3 (folds to 2) aborts the open frame
        pulse_start(2'd3);
        check("abort_ovf", 64'(overflow), 64'd1);
        pulse_clr();
        check("clr_ovf", 64'(overflow), 64'd0);
        fifo_almost_full = 1'b1;
        for (int unsigned w = 0; w < FW; w++)
            send_word(16'(w * 16), 0, 1'b0, 1'b1, 29'h10000 + 29'(w), w == FW - 1);
        fifo_almost_full = 1'b0;
        idle(2);
        check("frame_end_busy", 64'(busy), 64'd0);
        check("frame_end_ovf", 64'(overflow), 64'd0);
        send_word(16'h2000, 0, 1'b0, 1'b0, 29'h0, 1'b0);
        idle(2);

        // Full FIFO across the 3rd word completion
        pulse_start(2'd0);
        send_word(16'h3000, 0, 1'b0, 1'b1, 29'h0, 1'b0);
        send_word(16'h3010, 0, 1'b0, 1'b1, 29'h1, 1'b0);
        send_word(16'h3020, 0, 1'b1, 1'b0, 29'h2, 1'b0);
        send_word(16'h3030, 0, 1'b0, 1'b1, 29'h3, 1'b0);
        idle(2);
        check("full_ovf",   64'(overflow), 64'd1);
        check("full_drops", 64'(drop_count), 64'd1);
        pulse_clr();
        check("full_clr_ovf",   64'(overflow), 64'd0);
        check("full_clr_drops", 64'(drop_count), 64'd0);

        // Restart after 100 pixels: partial word 96..99 is discarded
        pulse_start(2'd1);
        pulse_clr();
        for (int unsigned w = 0; w < 6; w++)
            send_word(16'(100 + w * 16), 0, 1'b0, 1'b1, 29'h8000 + 29'(w), 1'b0);
        for (int unsigned i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            pix_valid = 1'b1;
            pix_data  = 16'hAA00 + 16'(i);
        end
        pulse_start(2'd2);
        check("restart_ovf", 64'(overflow), 64'd1);
        send_word(16'd500, 0, 1'b0, 1'b1, 29'h10000, 1'b0);

        // One pixel every three cycles
        send_word(16'd700, 2, 1'b0, 1'b1, 29'h10001, 1'b0);
        idle(3);
        pulse_clr();

        // Asynchronous reset halfway through a word
        for (int unsigned i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            pix_valid = 1'b1;
            pix_data  = 16'hB000 + 16'(i);
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_wr_en", 64'(fifo_wr_en), 64'd0);
        check("arst_data",  64'(|fifo_data), 64'd0);
        check("arst_busy",  64'(busy), 64'd0);
        check("arst_ovf",   64'(overflow), 64'd0);
        check("arst_drops", 64'(drop_count), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_word(16'hC000, 0, 1'b0, 1'b0, 29'h0, 1'b0);
        idle(4);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
